// File: rtl/hash_target_scan_pkg.sv
// Shared types and constants for the hash target scanner.
// The FSM encoding, the best-hash seed value and the result-record layout live here.
package hash_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE
    } scan_state_e;

    localparam logic [31:0] BEST_INIT = 32'hFFFF_FFFF;

    // Word offsets within the result record; RES_WORDS doubles as the write-phase terminal count
    localparam logic [1:0] RES_FOUND = 2'd0;
    localparam logic [1:0] RES_NONCE = 2'd1;
    localparam logic [1:0] RES_HASH  = 2'd2;
    localparam logic [1:0] RES_WORDS = 2'd3;

endpackage

// File: rtl/hash_target_scan_min_tracker.sv
// Running-minimum tracker: keeps the smallest value seen since the last clear and its tag.
// The first valid word after a clear always loads, so an all-ones scan still reports its first nonce.
module hash_min_tracker
    import hash_scan_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic [31:0] idx_i,
    output logic [31:0] min_val_o,
    output logic [31:0] min_idx_o,
    output logic [31:0] next_val_o
);

    logic        have_q;
    logic [31:0] min_q;
    logic [31:0] idx_q;
    logic        take_d;

    // Words arrive in ascending index order, so a strict compare keeps the lower index on ties
    assign take_d     = valid_i && (!have_q || (data_i < min_q));
    assign next_val_o = take_d ? data_i : min_q;
    assign min_val_o  = min_q;
    assign min_idx_o  = idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            have_q <= 1'b0;
            min_q  <= BEST_INIT;
            idx_q  <= '0;
        end else if (take_d) begin
            have_q <= 1'b1;
            min_q  <= data_i;
            idx_q  <= idx_i;
        end
    end

endmodule

// File: rtl/hash_target_scan.sv
// Scans NUM_NONCES hash words from memory, finds the smallest and its nonce, tests it
// against a latched target, and writes a three-word result record back to memory.
module hash_target_scan
    import hash_scan_pkg::*;
#(
    parameter int unsigned NUM_NONCES = 16,
    parameter logic [31:0] NONCE_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [16:0] LAST_IDX = 17'(NUM_NONCES);

    scan_state_e state_q;
    logic [15:0] hash_addr_q;
    logic [15:0] result_addr_q;
    logic [31:0] target_q;
    logic [16:0] rd_idx_q;
    logic [1:0]  wr_idx_q;
    logic        vld_q;
    logic [15:0] vidx_q;
    logic        done_q;
    logic        found_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        clear_d;
    logic        found_d;
    logic [31:0] next_min_d;
    logic [31:0] wdata_d;
    logic [31:0] nonce_d;

    assign mem_clk        = clk;
    assign done           = done_q;
    assign found          = found_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

    assign clear_d = (state_q == ST_IDLE) && start;
    assign nonce_d = NONCE_BASE + {16'b0, vidx_q};
    // The final word is folded in on the DRAIN edge, so found must see the post-compare minimum
    assign found_d = next_min_d < target_q;

    hash_min_tracker u_min (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (clear_d),
        .valid_i    (vld_q),
        .data_i     (mem_read_data),
        .idx_i      (nonce_d),
        .min_val_o  (best_hash),
        .min_idx_o  (best_nonce),
        .next_val_o (next_min_d)
    );

    always_comb begin
        wdata_d = best_hash;
        case (wr_idx_q)
            RES_FOUND: wdata_d = {31'b0, found_q};
            RES_NONCE: wdata_d = best_nonce;
            RES_HASH:  wdata_d = best_hash;
            default:   wdata_d = best_hash;
        endcase
    end

    // Read address k goes out on edge k; its data is tagged valid one edge later and
    // compared the edge after that, which is why DRAIN is needed for the last word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            hash_addr_q   <= '0;
            result_addr_q <= '0;
            target_q      <= '0;
            rd_idx_q      <= '0;
            wr_idx_q      <= '0;
            vld_q         <= 1'b0;
            vidx_q        <= '0;
            done_q        <= 1'b1;
            found_q       <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_we_q <= 1'b0;
                    vld_q    <= 1'b0;
                    if (start) begin
                        hash_addr_q   <= hash_addr;
                        result_addr_q <= result_addr;
                        target_q      <= target;
                        mem_addr_q    <= hash_addr;
                        found_q       <= 1'b0;
                        rd_idx_q      <= 17'd1;
                        done_q        <= 1'b0;
                        state_q       <= ST_READ;
                    end
                end
                ST_READ: begin
                    vld_q  <= 1'b1;
                    vidx_q <= rd_idx_q[15:0] - 16'd1;
                    if (rd_idx_q < LAST_IDX) begin
                        mem_addr_q <= hash_addr_q + rd_idx_q[15:0];
                        rd_idx_q   <= rd_idx_q + 17'd1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    vld_q    <= 1'b0;
                    found_q  <= found_d;
                    wr_idx_q <= '0;
                    state_q  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_idx_q != RES_WORDS) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= result_addr_q + {14'b0, wr_idx_q};
                        mem_wdata_q <= wdata_d;
                        wr_idx_q    <= wr_idx_q + 2'd1;
                    end else begin
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_target_scan.sv
// Randomised bench for hash_target_scan: a memory model feeds hash words and a plain
// min-search reference predicts the result ports and the three-word record written back.
module tb_hash_target_scan;

    localparam int          NN = 16;
    localparam logic [31:0] NB = 32'd32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = '0;
    logic [15:0] result_addr = '0;
    logic [31:0] target = '0;
    logic        done, found, mem_clk, mem_we;
    logic [31:0] best_nonce, best_hash, mem_write_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];
    logic [47:0] wq[$];
    logic [15:0] rq[$];

    int checks = 0;
    int failures = 0;

    logic        clr_found, clr_done;
    logic [31:0] clr_hash, clr_nonce;

    hash_target_scan #(.NUM_NONCES(NN), .NONCE_BASE(NB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr),
        .result_addr(result_addr), .target(target), .done(done), .found(found),
        .best_nonce(best_nonce), .best_hash(best_hash), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for the address presented in one cycle appears in the next
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    // Log every write and every distinct read address issued while a scan is in flight
    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_write_data});
        if (reset_n && !done && !mem_we && (rq.size() == 0 || rq[$] != mem_addr))
            rq.push_back(mem_addr);
    end

    task automatic model(input logic [15:0] ha, input logic [31:0] tgt,
                         output logic [31:0] eh, output logic [31:0] en, output logic ef);
        eh = 32'hFFFF_FFFF;
        en = NB;
        for (int i = 0; i < NN; i++) begin
            logic [31:0] v;
            v = mem[16'(ha + 16'(i))];
            if (i == 0 || v < eh) begin
                eh = v;
                en = NB + 32'(i);
            end
        end
        ef = eh < tgt;
    endtask

    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tgt,
                            input int pulse_at, output int lat);
        wq.delete();
        rq.delete();
        @(negedge clk);
        hash_addr = ha; result_addr = ra; target = tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr_found = found; clr_done = done; clr_hash = best_hash; clr_nonce = best_nonce;
        hash_addr = 16'($urandom); result_addr = 16'($urandom); target = $urandom;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == pulse_at) begin
                start = 1'b1; hash_addr = 16'($urandom); target = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done && c > 1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_done got=%0b exp=1", done); end
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL rst_found got=%0b exp=0", found); end
        checks++; if (best_nonce !== 32'd0) begin failures++; $display("[TB] FAIL rst_nonce got=%h exp=0", best_nonce); end
        checks++; if (best_hash !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rst_hash got=%h exp=ffffffff", best_hash); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%0b exp=0", mem_we); end
        checks++; if (mem_addr !== 16'd0) begin failures++; $display("[TB] FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_write_data !== 32'd0) begin failures++; $display("[TB] FAIL rst_wdata got=%h exp=0", mem_write_data); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_found_basic(input logic [31:0] tgt, input logic exp_found);
        int lat;
        logic [47:0] ew [3];
        for (int i = 0; i < NN; i++) mem[16'h0100 + 16'(i)] = 32'd1000;
        mem[16'h0100] = 32'd100;
        mem[16'h0101] = 32'd50;
        run_scan(16'h0100, 16'h0200, tgt, 0, lat);
        ew[0] = {16'h0200, 31'b0, exp_found};
        ew[1] = {16'h0201, NB + 32'd1};
        ew[2] = {16'h0202, 32'd50};
        checks++; if (clr_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_fall got=%0b exp=0", clr_done); end
        checks++; if (lat != 21) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=21", lat); end
        checks++; if (found !== exp_found) begin failures++; $display("[TB] FAIL basic_found tgt=%0d got=%0b exp=%0b", tgt, found, exp_found); end
        checks++; if (best_nonce !== NB + 32'd1) begin failures++; $display("[TB] FAIL basic_nonce got=%0d exp=%0d", best_nonce, NB + 1); end
        checks++; if (best_hash !== 32'd50) begin failures++; $display("[TB] FAIL basic_hash got=%0d exp=50", best_hash); end
        checks++;
        if (wq.size() != 3) begin
            failures++; $display("[TB] FAIL basic_wr_count got=%0d exp=3", wq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wq[k] !== ew[k]) begin failures++; $display("[TB] FAIL basic_wr%0d got=%h exp=%h", k, wq[k], ew[k]); end
            end
        end
        checks++;
        if (rq.size() != NN) begin
            failures++; $display("[TB] FAIL basic_rd_count got=%0d exp=%0d", rq.size(), NN);
        end else begin
            for (int k = 0; k < NN; k++)
                if (rq[k] !== 16'h0100 + 16'(k)) begin failures++; $display("[TB] FAIL basic_rd%0d got=%h exp=%h", k, rq[k], 16'h0100 + 16'(k)); break; end
        end
    endtask

    task automatic test_tie();
        int lat;
        for (int i = 0; i < NN; i++) mem[16'h0400 + 16'(i)] = $urandom_range(32'hFFFF_FFFF, 32'd8);
        mem[16'h0403] = 32'd7;
        mem[16'h0409] = 32'd7;
        run_scan(16'h0400, 16'h0500, $urandom, 0, lat);
        checks++; if (best_nonce !== NB + 32'd3) begin failures++; $display("[TB] FAIL tie_nonce got=%0d exp=%0d", best_nonce, NB + 3); end
        checks++; if (best_hash !== 32'd7) begin failures++; $display("[TB] FAIL tie_hash got=%0d exp=7", best_hash); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [47:0] ew [3];
        for (int i = 0; i < NN; i++) mem[16'hFFF8 + 16'(i)] = 32'hFFFF_FFFF;
        run_scan(16'hFFF8, 16'hFFFE, 32'hFFFF_FFFF, 0, lat);
        ew[0] = {16'hFFFE, 32'd0};
        ew[1] = {16'hFFFF, NB};
        ew[2] = {16'h0000, 32'hFFFF_FFFF};
        checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL wrap_found got=%0b exp=0", found); end
        checks++; if (best_nonce !== NB) begin failures++; $display("[TB] FAIL wrap_nonce got=%0d exp=%0d", best_nonce, NB); end
        checks++; if (best_hash !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_hash got=%h exp=ffffffff", best_hash); end
        checks++;
        if (wq.size() != 3) begin
            failures++; $display("[TB] FAIL wrap_wr_count got=%0d exp=3", wq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wq[k] !== ew[k]) begin failures++; $display("[TB] FAIL wrap_wr%0d got=%h exp=%h", k, wq[k], ew[k]); end
            end
        end
        checks++;
        if (rq.size() != NN || rq[0] !== 16'hFFF8 || rq[7] !== 16'hFFFF || rq[8] !== 16'h0000 || rq[NN-1] !== 16'h0007) begin
            failures++; $display("[TB] FAIL wrap_rd_addrs count=%0d first=%h last=%h exp=16 fff8 0007", rq.size(), rq[0], rq[$]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int lat;
            logic [15:0] ha, ra;
            logic [31:0] tgt, eh, en;
            logic ef;
            ha = 16'($urandom);
            ra = ha + 16'h8000;
            for (int i = 0; i < NN; i++)
                mem[16'(ha + 16'(i))] = (it[0]) ? $urandom_range(32'd300, 32'd0) : $urandom;
            model(ha, 32'd0, eh, en, ef);
            tgt = (it < 2) ? $urandom : eh + 32'(it - 2);
            model(ha, tgt, eh, en, ef);
            run_scan(ha, ra, tgt, 0, lat);
            checks++; if (found !== ef) begin failures++; $display("[TB] FAIL rand%0d_found got=%0b exp=%0b", it, found, ef); end
            checks++; if (best_nonce !== en) begin failures++; $display("[TB] FAIL rand%0d_nonce got=%0d exp=%0d", it, best_nonce, en); end
            checks++; if (best_hash !== eh) begin failures++; $display("[TB] FAIL rand%0d_hash got=%h exp=%h", it, best_hash, eh); end
            checks++;
            if (wq.size() != 3 || wq[0] !== {ra, 31'b0, ef} || wq[1] !== {16'(ra + 16'd1), en} || wq[2] !== {16'(ra + 16'd2), eh})
                begin failures++; $display("[TB] FAIL rand%0d_record count=%0d exp=3 found=%0b nonce=%h hash=%h", it, wq.size(), ef, en, eh); end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [31:0] eh, en, tgt;
        logic ef;
        for (int i = 0; i < NN; i++) mem[16'h0600 + 16'(i)] = $urandom;
        tgt = $urandom;
        model(16'h0600, tgt, eh, en, ef);
        run_scan(16'h0600, 16'h0700, tgt, 5, lat);
        checks++; if (lat != 21) begin failures++; $display("[TB] FAIL ign_latency got=%0d exp=21", lat); end
        checks++; if (found !== ef || best_nonce !== en || best_hash !== eh)
            begin failures++; $display("[TB] FAIL ign_result got=%0b/%h/%h exp=%0b/%h/%h", found, best_nonce, best_hash, ef, en, eh); end
        checks++; if (wq.size() != 3 || wq[2] !== {16'h0702, eh})
            begin failures++; $display("[TB] FAIL ign_record count=%0d exp=3 hash=%h", wq.size(), eh); end
    endtask

    task automatic test_reset_mid_write();
        int nw = 0;
        int c;
        for (int i = 0; i < NN; i++) mem[16'h0800 + 16'(i)] = $urandom_range(32'd1000, 32'd0);
        wq.delete();
        @(negedge clk);
        hash_addr = 16'h0800; result_addr = 16'h0900; target = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 200 && nw < 2; c++) begin
            @(posedge clk);
            #1;
            if (mem_we) nw++;
        end
        checks++;
        if (nw != 2) begin
            failures++; $display("[TB] FAIL rstw_reach_write got=%0d exp=2", nw);
        end else begin
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rstw_we got=%0b exp=0", mem_we); end
            checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rstw_done got=%0b exp=1", done); end
            checks++; if (best_hash !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rstw_hash got=%h exp=ffffffff", best_hash); end
            checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL rstw_found got=%0b exp=0", found); end
            reset_n = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            checks++; if (wq.size() != 2) begin failures++; $display("[TB] FAIL rstw_write_count got=%0d exp=2", wq.size()); end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] eh, en, ta, tb;
        logic ef;
        for (int i = 0; i < NN; i++) mem[16'h0A00 + 16'(i)] = $urandom_range(32'd5000, 32'd1000);
        for (int i = 0; i < NN; i++) mem[16'h0B00 + 16'(i)] = $urandom_range(32'd900, 32'd100);
        ta = 32'd3000;
        run_scan(16'h0A00, 16'h0C00, ta, 0, lat);
        model(16'h0A00, ta, eh, en, ef);
        repeat (4) begin
            @(negedge clk);
            hash_addr = 16'($urandom); target = $urandom; start = 1'b0;
        end
        checks++; if (done !== 1'b1 || found !== ef || best_nonce !== en || best_hash !== eh)
            begin failures++; $display("[TB] FAIL b2b_hold got=%0b/%0b/%h/%h exp=1/%0b/%h/%h", done, found, best_nonce, best_hash, ef, en, eh); end
        tb = 32'd500;
        model(16'h0B00, tb, eh, en, ef);
        run_scan(16'h0B00, 16'h0C00, tb, 0, lat);
        checks++; if (clr_done !== 1'b0 || clr_found !== 1'b0 || clr_hash !== 32'hFFFF_FFFF || clr_nonce !== 32'd0)
            begin failures++; $display("[TB] FAIL b2b_clear got=%0b/%0b/%h/%h exp=0/0/ffffffff/0", clr_done, clr_found, clr_hash, clr_nonce); end
        checks++; if (found !== ef || best_nonce !== en || best_hash !== eh)
            begin failures++; $display("[TB] FAIL b2b_second got=%0b/%h/%h exp=%0b/%h/%h", found, best_nonce, best_hash, ef, en, eh); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
        test_reset();
        test_found_basic(32'd60, 1'b1);
        test_found_basic(32'd50, 1'b0);
        test_tie();
        test_wrap();
        test_random();
        test_start_ignored();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_target_scan.md
Name: hash_target_scan

Overview:
- Downstream of the nonce-parallel SHA-256 hasher, which writes NUM_NONCES 32-bit final-hash words (H0 per nonce, nonce order) to shared memory starting at its output address.
- This block reads those words, finds the numerically smallest hash and its nonce, and compares that hash against a 32-bit target.
- It writes a 3-word result record back to memory and also holds the result on ports for the host.

Parameters:
- NUM_NONCES, 16, number of hash words to scan (≥1, ≤65536).
- NONCE_BASE, 0, nonce value of hash word 0; word i carries nonce NONCE_BASE+i.

Ports:
- clk  in  1  system clock; mem_clk driven from it.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- hash_addr  in  16  base address of the hash words.
- result_addr  in  16  base address of the 3-word result record.
- target  in  32  difficulty threshold, unsigned.
- done  out  1  high when state==IDLE.
- found  out  1  best_hash < target.
- best_nonce  out  32  nonce of smallest hash.
- best_hash  out  32  smallest hash value.
- mem_clk  out  1  = clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address, registered.
- mem_write_data  out  32  memory write data, registered.
- mem_read_data  in  32  read data; valid the cycle after mem_addr is presented.

Behaviour:
- Reset (sync, reset_n=0 at an edge): state=IDLE, done=1, found=0, best_nonce=0, best_hash=32'hFFFF_FFFF, mem_we=0, mem_addr=0, mem_write_data=0, internal indices=0. A reset asserted mid-scan or mid-write aborts the operation at that edge. No further writes occur, and partial results are discarded.
- States: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - start=1 at edge E0 latches hash_addr, result_addr and target, and sets mem_addr=hash_addr.
  - It also sets best_hash=FFFF_FFFF, best_nonce=0, found=0, rd_idx=1, and state=READ.
  - start=0 holds all outputs, so results stay stable until the next start.
- READ:
  - Each edge Ek (k=1..NUM_NONCES-1) sets mem_addr=hash_addr+k, wrapping at 16 bits.
  - A one-cycle valid pipe tags the data for word k-1 as arriving at edge Ek.
  - Compare at each valid edge: if data < best_hash (strict, unsigned), then best_hash=data and best_nonce=NONCE_BASE+index. Ties keep the lower index.
  - After the last address is issued, state=DRAIN.
- DRAIN: one edge compares the final word, then found = (best_hash < target), with target latched at start. State=WRITE and wr_idx=0.
- WRITE: three consecutive edges register mem_we=1 with these address/data pairs:
  - result_addr+0 gets {31'b0, found}.
  - result_addr+1 gets best_nonce.
  - result_addr+2 gets best_hash.
  - The following edge sets mem_we=0 and state=IDLE.
- mem_we=0 in every state other than WRITE. No reads are issued during WRITE.
- Latency: done falls the cycle after E0 and rises NUM_NONCES+5 edges after E0 (21 for the default).
- start while not IDLE is ignored; there is no queuing.
- target=0 gives found=0 always. All hashes = FFFF_FFFF gives best_nonce=NONCE_BASE, found=0 for any target.
- Address wrap: both hash_addr+k and result_addr+2 wrap modulo 2^16.
- NUM_NONCES=1: READ is a single edge, then DRAIN.

Decomposition:
- Package hash_scan_pkg holds:
  - the state enum;
  - localparam BEST_INIT=32'hFFFF_FFFF;
  - result-record offsets RES_FOUND=0, RES_NONCE=1, RES_HASH=2, RES_WORDS=3.
- One natural sub-module, hash_min_tracker. It takes clear, valid, data and idx, and provides registered min value plus index with lower-index tie-break.
- The top level owns the FSM and the memory port.

Test Plan:
- Hashes 100,50,...(others 1000), word 1=50, target=60 → found=1, best_nonce=1, best_hash=50; mem writes (ra,1),(ra+1,1),(ra+2,50); done rises 21 edges after start.
- Same data, target=50 → found=0 (strict compare), best_nonce=1, best_hash=50, record word0=0.
- Words 3 and 9 both =7, others larger, NONCE_BASE=32 → best_nonce=35 (lower index wins), best_hash=7.
- All hashes FFFF_FFFF, target=FFFF_FFFF → found=0, best_nonce=0, best_hash=FFFF_FFFF; hash_addr=16'hFFF8 → read addresses wrap FFF8..0007.
- Pulse start at cycle 5 of the scan → ignored, the result matches the undisturbed run. Then reset_n=0 during the second WRITE edge → mem_we=0 at the next edge, done=1, best_hash=FFFF_FFFF, found=0, and no third write.
- Two back-to-back scans with different data → outputs hold the first results until the second start, then clear and reflect the second data only.
